// File: rtl/booth_r4_seq_multiplier.sv
// booth_r4_seq_multiplier
//   Iterative signed radix-4 Booth multiplier. One overlapping multiplier
//   triplet is recoded per RUN cycle into SNGL/DBL/NEG. The matching partial
//   product row (0, +-M, +-2M) is shifted into place and added into a 2N-bit
//   accumulator, so a product takes N/2 iterations.
// Ports
//   CLK, RST       rising-edge clock, asynchronous active-high reset
//   Start          request, sampled only in IDLE (with both operands)
//   Multiplicand   signed M, N bits
//   Multiplier     signed Y, N bits
//   Busy           high while iterating
//   Done           one-cycle pulse when Product is updated
//   Product        signed M*Y, 2N bits, held until the next completion
//   SNGL/DBL/NEG   Booth recoding of the current triplet, 0 when not Busy
module booth_r4_seq_multiplier #(
  parameter int N = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Product,
  output logic           SNGL,
  output logic           DBL,
  output logic           NEG
);

  localparam int HALF = N / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [N-1:0]   m;
  logic [N:0]     sr;      // {Y, 1'b0}, consumed two bits per iteration
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;

  logic           b2, b1, b0;
  logic           sngl_raw, dbl_raw, neg_raw;
  logic [2*N-1:0] m_ext, row_sel, row, row_sh, acc_next;

  assign {b2, b1, b0} = sr[2:0];

  assign sngl_raw = b1 ^ b0;
  assign dbl_raw  = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
  // 111 selects a zero row, so it is left positive.
  assign neg_raw  = b2 & ~(b1 & b0);

  assign SNGL = Busy & sngl_raw;
  assign DBL  = Busy & dbl_raw;
  assign NEG  = Busy & neg_raw;

  // Row is built in 2N bits so 2M of the most negative M cannot overflow.
  always_comb begin
    m_ext    = {{N{m[N-1]}}, m};
    row_sel  = sngl_raw ? m_ext : (dbl_raw ? (m_ext << 1) : '0);
    row      = neg_raw ? (-row_sel) : row_sel;
    row_sh   = row << {cnt, 1'b0};
    acc_next = acc + row_sh;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      m       <= '0;
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            m     <= Multiplicand;
            sr    <= {Multiplier, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          sr  <= {sr[N], sr[N], sr[N:2]};   // arithmetic shift by 2
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            Product <= acc_next;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Directed and random checks of booth_r4_seq_multiplier at N=8.
module tb_booth_r4_seq_multiplier;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [7:0]  Multiplicand, Multiplier;
  logic        Busy, Done;
  logic [15:0] Product;
  logic        SNGL, DBL, NEG;

  int errors = 0;
  int checks = 0;

  booth_r4_seq_multiplier #(.N(8)) dut (
    .CLK(CLK), .RST(RST), .Start(Start),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Busy(Busy), .Done(Done), .Product(Product),
    .SNGL(SNGL), .DBL(DBL), .NEG(NEG)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge after E0.
  task automatic start_op(input logic [7:0] m, input logic [7:0] y);
    @(negedge CLK);
    Start = 1'b1; Multiplicand = m; Multiplier = y;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Steps negedges until Done, bounded; counts Busy cycles seen on the way.
  task automatic wait_done(output int busy_n, output bit got);
    busy_n = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (Done === 1'b1) begin got = 1'b1; break; end
      if (Busy === 1'b1) busy_n++;
      @(negedge CLK);
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] m, input logic [7:0] y,
                       input logic [15:0] exp, input bit full);
    int bn; bit got;
    start_op(m, y);
    wait_done(bn, got);
    chk({tag, "_done"}, 64'(got), 64'd1);
    chk({tag, "_prod"}, 64'(Product), 64'(exp));
    if (full) begin
      chk({tag, "_busy_cycles"}, 64'(bn), 64'd4);
      @(negedge CLK);
      chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
      chk({tag, "_idle"}, 64'(Busy), 64'd0);
    end
  endtask

  initial begin
    int bn, gap, extra; bit got, hold_ok;
    logic [7:0] rm, ry;
    logic signed [15:0] rexp;

    RST = 1'b1; Start = 1'b0; Multiplicand = '0; Multiplier = '0;
    #12;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_prod", 64'(Product), 64'd0);
    chk("rst_enc", 64'({SNGL, DBL, NEG}), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Basic product, latency and pulse width.
    do_op("t1_3x5", 8'd3, 8'd5, 16'h000F, 1'b1);

    // -7 * 6: triplets 100, 011, 000, 000.
    start_op(8'hF9, 8'h06);
    chk("t2_it0_enc", 64'({SNGL, DBL, NEG}), 64'b011);
    @(negedge CLK);
    chk("t2_it1_enc", 64'({SNGL, DBL, NEG}), 64'b010);
    @(negedge CLK);
    chk("t2_it2_enc", 64'({SNGL, DBL, NEG}), 64'b000);
    @(negedge CLK);
    chk("t2_it3_enc", 64'({SNGL, DBL, NEG}), 64'b000);
    chk("t2_it3_busy", 64'(Busy), 64'd1);
    wait_done(bn, got);
    chk("t2_done", 64'(got), 64'd1);
    chk("t2_prod", 64'(Product), 64'hFFD6);
    @(negedge CLK);
    chk("t2_idle_enc", 64'({SNGL, DBL, NEG}), 64'd0);

    // Corners.
    do_op("t3_m128sq", 8'h80, 8'h80, 16'h4000, 1'b0);
    do_op("t3_127xm128", 8'h7F, 8'h80, 16'hC080, 1'b0);
    do_op("t3_m1xm1", 8'hFF, 8'hFF, 16'h0001, 1'b0);
    do_op("t3_0x55", 8'h00, 8'h55, 16'h0000, 1'b0);

    // Start re-asserted while busy is ignored.
    @(negedge CLK);
    Start = 1'b1; Multiplicand = 8'd2; Multiplier = 8'd2;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    Start = 1'b1; Multiplicand = 8'd9; Multiplier = 8'd9;
    @(negedge CLK);
    Start = 1'b0;
    wait_done(bn, got);
    chk("t4_done", 64'(got), 64'd1);
    chk("t4_prod", 64'(Product), 64'h0004);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (Done === 1'b1) extra++;
    end
    chk("t4_no_second_done", 64'(extra), 64'd0);
    chk("t4_idle", 64'(Busy), 64'd0);

    // Back-to-back: new request in the Done cycle.
    start_op(8'd2, 8'd2);
    wait_done(bn, got);
    chk("t5_first_done", 64'(got), 64'd1);
    chk("t5_first_prod", 64'(Product), 64'h0004);
    Start = 1'b1; Multiplicand = 8'hFD; Multiplier = 8'h04;
    @(negedge CLK);
    Start = 1'b0;
    gap = 0; got = 1'b0; hold_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (Done === 1'b1) begin got = 1'b1; break; end
      if (Product !== 16'h0004) hold_ok = 1'b0;
      gap++;
      @(negedge CLK);
    end
    chk("t5_second_done", 64'(got), 64'd1);
    chk("t5_gap_cycles", 64'(gap), 64'd4);
    chk("t5_hold", 64'(hold_ok), 64'd1);
    chk("t5_second_prod", 64'(Product), 64'hFFF4);

    // Reset in iteration 2 clears everything without a clock edge.
    start_op(8'd5, 8'd7);
    @(negedge CLK);
    @(negedge CLK);
    chk("t6_pre_busy", 64'(Busy), 64'd1);
    RST = 1'b1;
    #1;
    chk("t6_busy", 64'(Busy), 64'd0);
    chk("t6_done", 64'(Done), 64'd0);
    chk("t6_prod", 64'(Product), 64'd0);
    chk("t6_enc", 64'({SNGL, DBL, NEG}), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (Done === 1'b1) extra++;
    end
    chk("t6_no_done", 64'(extra), 64'd0);

    // Random operands against a signed reference.
    for (int i = 0; i < 1000; i++) begin
      rm = 8'($urandom);
      ry = 8'($urandom);
      rexp = $signed(rm) * $signed(ry);
      do_op("rand", rm, ry, rexp, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
